spi_flash_read_ctrl: RTL



---
 rtl/spi_flash_pkg.sv | 26 ++
 rtl/spi_flash_read_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/spi_flash_pkg.sv
`default_nettype none
// Shared constants, FSM encoding and header-byte helper for the SPI flash command sequencers.
// Rev 1.0 - initial release.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam int         HDR_BYTES = 4;
  localparam int         LEN_W     = 16;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_END_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  // Byte presented to the driver once byte index k is reached: address MSB first, then dummy zeros.
  function automatic logic [7:0] tx_byte(input logic [23:0] addr, input logic [LEN_W:0] k);
    logic [7:0] b;
    b = 8'h00;
    if (k == (LEN_W+1)'(1))      b = addr[23:16];
    else if (k == (LEN_W+1)'(2)) b = addr[15:8];
    else if (k == (LEN_W+1)'(3)) b = addr[7:0];
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_flash_read_ctrl.sv
`default_nettype none
// READ (0x03) command sequencer sitting in front of the mode-0 SPI byte driver.
// Rev 1.0 - initial release.
module spi_flash_read_ctrl
  import spi_flash_pkg::*;
(
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             req,
  input  logic [23:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  output logic             busy,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             spi_start,
  output logic             spi_end,
  output logic [7:0]       data_send,
  input  logic             send_done,
  input  logic             rec_done,
  input  logic [7:0]       data_rec,
  input  logic             spi_cs
);

  localparam logic [LEN_W:0] CNT_ONE = (LEN_W+1)'(1);
  localparam logic [LEN_W:0] HDR_CNT = (LEN_W+1)'(HDR_BYTES);

  logic [1:0]     state;
  logic [23:0]    addr;
  logic [LEN_W:0] total;
  logic [LEN_W:0] tx_idx;
  logic [LEN_W:0] rx_idx;
  logic [LEN_W:0] tx_next;
  logic           end_sent;
  logic           last_rx;

  assign tx_next = tx_idx + CNT_ONE;
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= ST_IDLE;
      addr      <= '0;
      total     <= '0;
      tx_idx    <= '0;
      rx_idx    <= '0;
      end_sent  <= 1'b0;
      last_rx   <= 1'b0;
      rd_data   <= 8'h00;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
      spi_start <= 1'b0;
      spi_end   <= 1'b0;
      data_send <= 8'h00;
    end else begin
      spi_start <= 1'b0;
      spi_end   <= 1'b0;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (req_len != '0) begin
              addr      <= req_addr;
              total     <= {1'b0, req_len} + HDR_CNT;
              tx_idx    <= '0;
              rx_idx    <= '0;
              end_sent  <= 1'b0;
              last_rx   <= 1'b0;
              data_send <= CMD_READ;
              spi_start <= 1'b1;
              state     <= ST_RUN;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (send_done && !end_sent) begin
            tx_idx <= tx_next;
            // Last byte: keep data_send as-is and tell the driver to close the frame.
            if (tx_idx == total - CNT_ONE) begin
              spi_end  <= 1'b1;
              end_sent <= 1'b1;
            end else begin
              data_send <= tx_byte(addr, tx_next);
            end
          end
          if (rec_done && !last_rx) begin
            rx_idx <= rx_idx + CNT_ONE;
            if (rx_idx >= HDR_CNT) begin
              rd_data  <= data_rec;
              rd_valid <= 1'b1;
            end
            if (rx_idx == total - CNT_ONE) begin
              last_rx <= 1'b1;
            end
          end
          if (end_sent && last_rx) begin
            state <= ST_END_WAIT;
          end
        end
        ST_END_WAIT: begin
          if (spi_cs) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        default: begin
          // Empty requests arrive here with done low and spend one extra cycle raising it.
          if (done) begin
            state <= ST_IDLE;
          end else begin
            done <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire
